// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8N1 serial transmitter with 4-entry byte FIFO
module uart_tx_buf #(
   parameter int CLK_HZ = 27000000,
   parameter int BAUD   = 115200,
   parameter int DIV    = CLK_HZ / BAUD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       start,
   output logic       txd,
   output logic       rdy,
   output logic       busy,
   output logic [2:0] level,
   output logic       overflow
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_d;
   logic            start_q;
   logic [7:0]      mem [4];
   logic [1:0]      wptr, rptr;
   logic [2:0]      count;
   logic [7:0]      shift, shift_d;
   logic [2:0]      idx, idx_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            txd_d;
   logic            pop;

   logic full, empty, push, accept, bit_end;

   assign full    = (count == 3'd4);
   assign empty   = (count == 3'd0);
   assign push    = start & ~start_q;
   assign accept  = push & ~full;
   assign bit_end = (cnt == CNT_LAST);

   assign rdy   = ~full;
   assign busy  = (state != IDLE) | ~empty;
   assign level = count;

   always_comb begin
      state_d = state;
      shift_d = shift;
      idx_d   = idx;
      cnt_d   = cnt;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem[rptr];
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift[7:1]};
               idx_d   = idx + 3'd1;
               if (idx == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         STOP: begin
            // Chain straight into the next start bit so bursts have no idle gap.
            if (bit_end) begin
               cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rptr];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // txd is registered from the next state, so the line changes with the state.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         wptr     <= 2'd0;
         rptr     <= 2'd0;
         count    <= 3'd0;
         shift    <= 8'd0;
         idx      <= 3'd0;
         cnt      <= '0;
         txd      <= 1'b1;
         overflow <= 1'b0;
      end else begin
         start_q <= start;
         state   <= state_d;
         shift   <= shift_d;
         idx     <= idx_d;
         cnt     <= cnt_d;
         txd     <= txd_d;
         if (accept) wptr <= wptr + 2'd1;
         if (pop)    rptr <= rptr + 2'd1;
         count <= count + {2'b00, accept} - {2'b00, pop};
         if (push && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= data;
   end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench for uart_tx_buf at DIV=234 and DIV=4
module tb_uart_tx_buf;
   localparam int DIV_A = 27000000 / 115200;
   localparam int DIV_B = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_a = 8'd0, data_b = 8'd0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       txd_a, rdy_a, busy_a, overflow_a;
   logic       txd_b, rdy_b, busy_b, overflow_b;
   logic [2:0] level_a, level_b;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_start = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_buf #(.CLK_HZ(27000000), .BAUD(115200)) dut_a (
      .clk(clk), .reset(reset), .data(data_a), .start(start_a), .txd(txd_a),
      .rdy(rdy_a), .busy(busy_a), .level(level_a), .overflow(overflow_a));

   uart_tx_buf #(.CLK_HZ(4), .BAUD(1)) dut_b (
      .clk(clk), .reset(reset), .data(data_b), .start(start_b), .txd(txd_b),
      .rdy(rdy_b), .busy(busy_b), .level(level_b), .overflow(overflow_b));

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_frame(input bit use_b, input int timeout);
      int div;
      int waited;
      logic [7:0] got;
      logic [7:0] exp;
      div = use_b ? DIV_B : DIV_A;
      waited = 0;
      @(negedge clk);
      while ((use_b ? txd_b : txd_a) !== 1'b0 && waited < timeout) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (waited >= timeout) begin
         fails++;
         $display("FAIL rx_start: no start bit within %0d cycles (dut %0d)", timeout, use_b);
         return;
      end
      last_start = cyc;
      for (int k = 0; k < 8; k++) begin
         tick(div);
         got[k] = use_b ? txd_b : txd_a;
      end
      tick(div);
      tests++;
      if ((use_b ? txd_b : txd_a) !== 1'b1) begin
         fails++;
         $display("FAIL rx_stop: got %b expected 1", use_b ? txd_b : txd_a);
      end
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL rx_extra: got unexpected byte %02h expected none", got);
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            fails++;
            $display("FAIL rx_byte: got %02h expected %02h", got, exp);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(3);
      tests++;
      if ({txd_a, rdy_a, busy_a, level_a, overflow_a} !== 7'b1100000) begin
         fails++;
         $display("FAIL reset_a: got txd/rdy/busy/level/ovf %b expected 1100000",
                  {txd_a, rdy_a, busy_a, level_a, overflow_a});
      end
      tests++;
      if ({txd_b, rdy_b, busy_b, level_b, overflow_b} !== 7'b1100000) begin
         fails++;
         $display("FAIL reset_b: got %b expected 1100000",
                  {txd_b, rdy_b, busy_b, level_b, overflow_b});
      end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single;
      int e;
      data_a = 8'hA5;
      start_a = 1'b1;
      sb.push_back(8'hA5);
      tick(1);
      e = cyc;
      tests++;
      if (txd_a !== 1'b1 || level_a !== 3'd1) begin
         fails++;
         $display("FAIL single_push: got txd %b level %0d expected txd 1 level 1", txd_a, level_a);
      end
      rx_frame(1'b0, 4);
      tests++;
      if (last_start != e + 1) begin
         fails++;
         $display("FAIL single_latency: got start cycle %0d expected %0d", last_start, e + 1);
      end
      tick(DIV_A - 1);
      tests++;
      if (busy_a !== 1'b1) begin
         fails++;
         $display("FAIL single_busy_end: got %b expected 1", busy_a);
      end
      tick(1);
      tests++;
      if (busy_a !== 1'b0) begin
         fails++;
         $display("FAIL single_busy_idle: got %b expected 0", busy_a);
      end
      tick(20);
      tests++;
      if (busy_a !== 1'b0 || level_a !== 3'd0 || txd_a !== 1'b1) begin
         fails++;
         $display("FAIL single_held: got busy %b level %0d txd %b expected 0 0 1", busy_a, level_a, txd_a);
      end
      start_a = 1'b0;
      tick(2);
   endtask

   task automatic test_burst;
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               data_a = 8'(i);
               start_a = 1'b1;
               if (i <= 5) sb.push_back(8'(i));
               tick(1);
               if (i == 5) begin
                  tests++;
                  if (level_a !== 3'd4 || rdy_a !== 1'b0 || overflow_a !== 1'b0) begin
                     fails++;
                     $display("FAIL burst_full: got level %0d rdy %b ovf %b expected 4 0 0", level_a, rdy_a, overflow_a);
                  end
               end
               if (i == 6) begin
                  tests++;
                  if (level_a !== 3'd4 || overflow_a !== 1'b1) begin
                     fails++;
                     $display("FAIL burst_overflow: got level %0d ovf %b expected 4 1", level_a, overflow_a);
                  end
               end
               start_a = 1'b0;
               tick(1);
            end
         end
         begin
            int prev;
            prev = 0;
            for (int i = 0; i < 5; i++) begin
               rx_frame(1'b0, 12 * DIV_A);
               if (i > 0) begin
                  tests++;
                  if (last_start - prev != 10 * DIV_A) begin
                     fails++;
                     $display("FAIL burst_gap: got %0d cycles expected %0d", last_start - prev, 10 * DIV_A);
                  end
               end
               prev = last_start;
            end
         end
      join
      tick(DIV_A + 2);
      tests++;
      if (overflow_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) begin
         fails++;
         $display("FAIL burst_after: got ovf %b busy %b level %0d expected 1 0 0", overflow_a, busy_a, level_a);
      end
   endtask

   task automatic test_simultaneous;
      logic [7:0] bytes [4];
      bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h5A; bytes[3] = 8'h96;
      fork
         begin
            int e;
            for (int i = 0; i < 3; i++) begin
               data_a = bytes[i];
               start_a = 1'b1;
               sb.push_back(bytes[i]);
               tick(1);
               if (i == 0) e = cyc;
               start_a = 1'b0;
               tick(1);
            end
            while (cyc < e + 10 * DIV_A) tick(1);
            tests++;
            if (level_a !== 3'd2) begin
               fails++;
               $display("FAIL simul_pre: got level %0d expected 2", level_a);
            end
            data_a = bytes[3];
            start_a = 1'b1;
            sb.push_back(bytes[3]);
            tick(1);
            tests++;
            if (level_a !== 3'd2) begin
               fails++;
               $display("FAIL simul_level: got level %0d expected 2", level_a);
            end
            start_a = 1'b0;
         end
         begin
            for (int i = 0; i < 4; i++) rx_frame(1'b0, 12 * DIV_A);
         end
      join
      tick(DIV_A + 2);
   endtask

   task automatic test_reset_mid;
      int e;
      int lows;
      for (int i = 0; i < 3; i++) begin
         data_a = 8'hF0 + 8'(i);
         start_a = 1'b1;
         tick(1);
         if (i == 0) e = cyc;
         start_a = 1'b0;
         tick(1);
      end
      while (cyc < e + 1 + 4 * DIV_A + DIV_A / 2) tick(1);
      tests++;
      if (level_a !== 3'd2 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: got level %0d busy %b expected 2 1", level_a, busy_a);
      end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tests++;
      if ({txd_a, rdy_a, busy_a, level_a, overflow_a} !== 7'b1100000) begin
         fails++;
         $display("FAIL mid_reset: got txd/rdy/busy/level/ovf %b expected 1100000",
                  {txd_a, rdy_a, busy_a, level_a, overflow_a});
      end
      lows = 0;
      for (int i = 0; i < 12 * DIV_A; i++) begin
         tick(1);
         if (txd_a !== 1'b1) lows++;
      end
      tests++;
      if (lows != 0) begin
         fails++;
         $display("FAIL mid_quiet: got %0d non-idle cycles expected 0", lows);
      end
   endtask

   task automatic test_div4;
      int e;
      data_b = 8'h81;
      start_b = 1'b1;
      sb.push_back(8'h81);
      tick(1);
      e = cyc;
      start_b = 1'b0;
      rx_frame(1'b1, 4);
      tests++;
      if (last_start != e + 1) begin
         fails++;
         $display("FAIL div4_latency: got %0d expected %0d", last_start, e + 1);
      end
      tick(DIV_B - 1);
      tests++;
      if (busy_b !== 1'b1) begin
         fails++;
         $display("FAIL div4_busy_end: got %b expected 1", busy_b);
      end
      tick(1);
      tests++;
      if (busy_b !== 1'b0 || cyc != e + 10 * DIV_B + 1) begin
         fails++;
         $display("FAIL div4_frame: got busy %b at offset %0d expected 0 at %0d", busy_b, cyc - e, 10 * DIV_B + 1);
      end
      tick(3);
      fork
         begin
            int e2;
            for (int i = 1; i <= 5; i++) begin
               data_b = 8'(i * 8'h11);
               start_b = 1'b1;
               sb.push_back(8'(i * 8'h11));
               tick(1);
               if (i == 1) e2 = cyc;
               start_b = 1'b0;
               tick(1);
            end
            while (cyc < e2 + 10 * DIV_B) tick(1);
            tests++;
            if (level_b !== 3'd4 || overflow_b !== 1'b0 || txd_b !== 1'b1) begin
               fails++;
               $display("FAIL div4_pre: got level %0d ovf %b txd %b expected 4 0 1", level_b, overflow_b, txd_b);
            end
            data_b = 8'hEE;
            start_b = 1'b1;
            tick(1);
            tests++;
            if (overflow_b !== 1'b1 || level_b !== 3'd3 || txd_b !== 1'b0) begin
               fails++;
               $display("FAIL div4_drop: got ovf %b level %0d txd %b expected 1 3 0", overflow_b, level_b, txd_b);
            end
            start_b = 1'b0;
         end
         begin
            int prev;
            prev = 0;
            for (int i = 0; i < 5; i++) begin
               rx_frame(1'b1, 12 * DIV_B);
               if (i > 0) begin
                  tests++;
                  if (last_start - prev != 10 * DIV_B) begin
                     fails++;
                     $display("FAIL div4_gap: got %0d expected %0d", last_start - prev, 10 * DIV_B);
                  end
               end
               prev = last_start;
            end
         end
      join
      tick(2 * DIV_B);
      tests++;
      if (sb.size() != 0 || busy_b !== 1'b0) begin
         fails++;
         $display("FAIL div4_drain: got %0d pending busy %b expected 0 0", sb.size(), busy_b);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_simultaneous();
      test_reset_mid();
      test_div4();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
